sass_tx_arbiter: RTL and testbench

//  Shares one SASS serial transmitter among N_REQ requesters. Round-robin arbitration

---
 rtl/sass_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sass_tx_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sass_tx_arbiter.sv
// Round-robin (or fixed-priority) arbiter sharing one SASS serial
// transmitter among N_REQ requesters, with busy tracking and idle gap.
//
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   req             per-requester request level, held until ack
//   req_data        requester i word at [i*DATA_L +: DATA_L]
//   ack             1-cycle pulse: grant taken, data latched
//   done            1-cycle pulse: granted frame fully sent
//   err             1-cycle pulse: tx_busy never rose after send
//   tx_send         1-cycle send strobe to the transmitter
//   tx_data         word to the transmitter, stable while active
//   tx_busy         transmitter busy flag
//   grant_id        index of the current/last grant
//   active          high from grant until the idle gap ends
//
// Build option: define SASS_ARB_FIXED_PRIO_EN to make the lowest-index
// request always win; otherwise round-robin from the last winner.
module sass_tx_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int DATA_L  = 8,
  parameter  int GAP_CYC = 16,
  parameter  int BUSY_TO = 8,
  localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CMAX    = (GAP_CYC > BUSY_TO) ? GAP_CYC : BUSY_TO,
  localparam int CW      = $clog2(CMAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_L-1:0]  req_data,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         done,
  output logic                     err,
  output logic                     tx_send,
  output logic [DATA_L-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic [GW-1:0]            grant_id,
  output logic                     active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [N_REQ-1:0]    r_ack;
  logic [N_REQ-1:0]    r_done;
  logic                r_err;
  logic                r_send;
  logic [DATA_L-1:0]   r_data;
  logic [GW-1:0]       r_grant;
  logic                r_active;
`ifndef SASS_ARB_FIXED_PRIO_EN
  logic [GW-1:0]       r_ptr;
`endif

  logic                w_any;
  logic [GW-1:0]       w_win;
  logic [DATA_L-1:0]   w_data;
  int                  w_idx;

  // Winner search. The loop runs from the lowest priority slot to the
  // highest so the last hit (highest priority) is the one that sticks.
  always_comb begin
    w_any  = |req;
    w_win  = '0;
    w_data = '0;
    w_idx  = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
`ifdef SASS_ARB_FIXED_PRIO_EN
      w_idx = i;
`else
      w_idx = (int'(r_ptr) + 1 + i) % N_REQ;
`endif
      if (req[w_idx]) begin
        w_win  = GW'(w_idx);
        w_data = req_data[w_idx*DATA_L +: DATA_L];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ack    <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_send   <= 1'b0;
      r_data   <= '0;
      r_grant  <= '0;
      r_active <= 1'b0;
`ifndef SASS_ARB_FIXED_PRIO_EN
      // Last winner = N_REQ-1 so requester 0 wins first.
      r_ptr    <= GW'(N_REQ - 1);
`endif
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      r_err  <= 1'b0;
      r_send <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ack    <= N_REQ'(1) << w_win;
            r_data   <= w_data;
            r_grant  <= w_win;
            r_active <= 1'b1;
`ifndef SASS_ARB_FIXED_PRIO_EN
            r_ptr    <= w_win;
`endif
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_send  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // Count starts on the cycle tx_send is visible, so err lands
          // BUSY_TO cycles after the send strobe.
          if (tx_busy) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == CW'(BUSY_TO - 1)) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            r_done  <= N_REQ'(1) << r_grant;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          // tx_busy is deliberately ignored here.
          if (r_cnt == CW'(GAP_CYC - 1)) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt    <= '0;
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign done     = r_done;
  assign err      = r_err;
  assign tx_send  = r_send;
  assign tx_data  = r_data;
  assign grant_id = r_grant;
  assign active   = r_active;

endmodule

// File: tb/tb_sass_tx_arbiter.sv
// Directed bench for sass_tx_arbiter (N_REQ=4, DATA_L=8, GAP_CYC=16,
// BUSY_TO=8) with hand-computed expectations.
module tb_sass_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        err;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [1:0]  grant_id;
  logic        active;

  int n_chk  = 0;
  int n_fail = 0;
  int n_wait;

  sass_tx_arbiter #(
    .N_REQ  (4),
    .DATA_L (8),
    .GAP_CYC(16),
    .BUSY_TO(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_data(req_data),
    .ack     (ack),
    .done    (done),
    .err     (err),
    .tx_send (tx_send),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .grant_id(grant_id),
    .active  (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    tx_busy = 1'b0;
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_send", 32'(tx_send), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_active", 32'(active), 0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Ticks until an ack shows up; n = ticks taken.
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == 4'b0 && n < 60);
    if (ack == 4'b0) check("ack_timeout", 0, 1);
  endtask

  // One normal frame: ack, send, busy for 3 cycles, done.
  task automatic frame(input int id, input logic [7:0] d,
                       input int exp_n, input bit drop);
    int n;
    wait_ack(n);
    if (exp_n > 0) check($sformatf("gap%0d", id), n, exp_n);
    check($sformatf("ack%0d", id), 32'(ack), 32'(4'b1 << id));
    check($sformatf("gid%0d", id), 32'(grant_id), id);
    check("active_on", 32'(active), 1);
    if (drop) req[id] = 1'b0;
    tick();
    check("send_hi", 32'(tx_send), 1);
    check("tx_data", 32'(tx_data), 32'(d));
    tick();
    check("send_lo", 32'(tx_send), 0);
    tx_busy = 1'b1;
    repeat (3) tick();
    check("done_early", 32'(done), 0);
    tx_busy = 1'b0;
    tick();
    check($sformatf("done%0d", id), 32'(done), 32'(4'b1 << id));
    check("no_err", 32'(err), 0);
  endtask

  initial begin
    #2;
    // 1: single request, full frame, gap timing
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
    req      = 4'b0001;
    frame(0, 8'hA5, 1, 1'b1);
    tick();
    check("done_pulse", 32'(done), 0);
    repeat (14) tick();
    check("active_gap", 32'(active), 1);
    tick();
    check("active_off", 32'(active), 0);

    // 2: all requesting, round-robin order 0,1,2,3,0
    do_reset();
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req      = 4'b1111;
    frame(0, 8'hA0, 1, 1'b0);
    frame(1, 8'hB1, 17, 1'b0);
    frame(2, 8'hC2, 17, 1'b0);
    frame(3, 8'hD3, 17, 1'b0);
    frame(0, 8'hA0, 17, 1'b0);

    // 3: tx_busy never rises -> err 8 cycles after send
    do_reset();
    req = 4'b0001;
    wait_ack(n_wait);
    check("to_ack", 32'(ack), 1);
    tick();
    check("to_send", 32'(tx_send), 1);
    repeat (7) tick();
    check("to_err_early", 32'(err), 0);
    tick();
    check("to_err", 32'(err), 1);
    check("to_no_done", 32'(done), 0);
    wait_ack(n_wait);
    check("to_gap", n_wait, 17);
    check("to_ack2", 32'(ack), 1);

    // 4: reset during WAIT_DONE
    do_reset();
    req = 4'b0100;
    wait_ack(n_wait);
    check("r4_ack", 32'(ack), 32'(4'b0100));
    req = 4'b0;
    tick();
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("r4_active", 32'(active), 0);
    check("r4_data", 32'(tx_data), 0);
    check("r4_gid", 32'(grant_id), 0);
    tick();
    rst     = 1'b0;
    tx_busy = 1'b0;
    tick();
    tick();
    check("r4_no_done", 32'(done), 0);
    req = 4'b1001;
    wait_ack(n_wait);
    check("r4_first", 32'(ack), 1);
    check("r4_lat", n_wait, 1);

    // 5: req[2] raised while req[1] frame is in WAIT_DONE
    do_reset();
    req = 4'b0010;
    wait_ack(n_wait);
    check("r5_ack1", 32'(ack), 32'(4'b0010));
    req = 4'b0;
    tick();
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r5_no_ack", 32'(ack), 0);
    end
    tx_busy = 1'b0;
    tick();
    check("r5_done1", 32'(done), 32'(4'b0010));
    wait_ack(n_wait);
    check("r5_gap", n_wait, 17);
    check("r5_ack2", 32'(ack), 32'(4'b0100));

`ifdef SASS_ARB_FIXED_PRIO_EN
    // 6: fixed priority, req[1] wins every round
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req      = 4'b1010;
    frame(1, 8'h22, 1, 1'b0);
    frame(1, 8'h22, 17, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
